// File: rtl/param_dual_port_ram.sv
// param_dual_port_ram: parametrised dual-port synchronous RAM (A read/write, B read-only) with a built-in clear engine
//   clk      rising-edge clock
//   rst      asynchronous active-high reset; starts a full clear
//   clr_req  single-cycle request to zero the whole array
//   busy     high while the clear engine runs; port accesses are ignored
//   a_*      port A: en, we, addr, data in; out, valid one cycle after an accepted access
//   b_*      port B: en, addr in; out, valid one cycle after an accepted read
module param_dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  a_valid,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  b_valid
);
    typedef enum logic {CLEAR, READY} state_t;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH-1);
    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_next;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_a_out, r_b_out, w_a_old, w_b_old, w_a_rd, w_b_rd;
    logic                  r_a_valid, r_b_valid;
    logic                  w_a_acc, w_b_acc, w_a_in, w_b_in, w_a_wr, w_collide;
    assign busy     = r_state == CLEAR;
    assign w_a_acc  = !busy && a_en;
    assign w_b_acc  = !busy && b_en;
    assign w_a_in   = {1'b0, a_addr} < DEPTH_W;
    assign w_b_in   = {1'b0, b_addr} < DEPTH_W;
    // out-of-range writes are dropped so they never alias onto a real word
    assign w_a_wr   = w_a_acc && a_we && w_a_in;
    assign w_a_old  = w_a_in ? r_mem[a_addr] : '0;
    assign w_b_old  = w_b_in ? r_mem[b_addr] : '0;
    assign w_collide = w_a_wr && (b_addr == a_addr);
    assign w_a_rd   = (RDW_MODE != 0 && w_a_wr) ? a_data : w_a_old;
    assign w_b_rd   = (RDW_MODE != 0 && w_collide) ? a_data : w_b_old;
    assign a_out    = r_a_out;
    assign b_out    = r_b_out;
    assign a_valid  = r_a_valid;
    assign b_valid  = r_b_valid;
    always_comb begin
        w_next     = r_state;
        w_clr_next = r_clr_addr;
        if (r_state == CLEAR) begin
            w_clr_next = r_clr_addr + 1'b1;
            w_next     = (r_clr_addr == LAST) ? READY : CLEAR;
        end else if (clr_req) begin
            w_next     = CLEAR;
            w_clr_next = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
            r_a_out    <= '0;
            r_b_out    <= '0;
            r_a_valid  <= 1'b0;
            r_b_valid  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_clr_addr <= w_clr_next;
            r_a_valid  <= w_a_acc;
            r_b_valid  <= w_b_acc;
            if (w_a_acc) r_a_out <= w_a_rd;
            if (w_b_acc) r_b_out <= w_b_rd;
        end
    end
    // storage has no reset; the clear engine zeroes it one word per edge
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) r_mem[r_clr_addr] <= '0;
        else if (w_a_wr) r_mem[a_addr] <= a_data;
    end
endmodule

// File: tb/tb_param_dual_port_ram.sv
// tb_param_dual_port_ram: checks three RAM configurations against a word-level reference model
module tb_param_dual_port_ram;
    logic       clk = 0, rst = 0, clr_req = 0, a_en = 0, a_we = 0, b_en = 0;
    logic [5:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_data = 0;
    logic [7:0] ao [3], bo [3];
    logic       av [3], bv [3], bz [3];
    logic [7:0] mm [3][64];
    logic [7:0] ea [3], eb [3];
    logic       eav [3], ebv [3];
    int         cleft [3];
    int         dep [3] = '{64, 64, 48};
    int         mo [3]  = '{0, 1, 0};
    int         checks = 0, errors = 0;
    param_dual_port_ram #(.RDW_MODE(0)) d0 (.clk(clk), .rst(rst), .clr_req(clr_req), .busy(bz[0]), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_out(ao[0]), .a_valid(av[0]), .b_en(b_en), .b_addr(b_addr), .b_out(bo[0]), .b_valid(bv[0]));
    param_dual_port_ram #(.RDW_MODE(1)) d1 (.clk(clk), .rst(rst), .clr_req(clr_req), .busy(bz[1]), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_out(ao[1]), .a_valid(av[1]), .b_en(b_en), .b_addr(b_addr), .b_out(bo[1]), .b_valid(bv[1]));
    param_dual_port_ram #(.DEPTH(48)) d2 (.clk(clk), .rst(rst), .clr_req(clr_req), .busy(bz[2]), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_out(ao[2]), .a_valid(av[2]), .b_en(b_en), .b_addr(b_addr), .b_out(bo[2]), .b_valid(bv[2]));
    initial forever #5 clk = ~clk;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy[%0d]", k), 32'(bz[k]), 32'(cleft[k] > 0));
            chk($sformatf("a_valid[%0d]", k), 32'(av[k]), 32'(eav[k]));
            chk($sformatf("b_valid[%0d]", k), 32'(bv[k]), 32'(ebv[k]));
            chk($sformatf("a_out[%0d]", k), 32'(ao[k]), 32'(ea[k]));
            chk($sformatf("b_out[%0d]", k), 32'(bo[k]), 32'(eb[k]));
        end
    endtask
    task automatic mreset();
        for (int k = 0; k < 3; k++) begin
            cleft[k] = dep[k];
            ea[k] = 0; eb[k] = 0; eav[k] = 0; ebv[k] = 0;
            for (int j = 0; j < 64; j++) mm[k][j] = 0;
        end
    endtask
    task automatic step();
        bit ain, bin, wr;
        if (rst) begin
            mreset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (cleft[k] > 0) begin
                cleft[k]--;
                eav[k] = 0; ebv[k] = 0;
            end else begin
                ain = int'(a_addr) < dep[k];
                bin = int'(b_addr) < dep[k];
                wr  = a_en && a_we && ain;
                eav[k] = a_en; ebv[k] = b_en;
                if (a_en) ea[k] = (wr && mo[k] == 1) ? a_data : (ain ? mm[k][a_addr] : 8'h00);
                if (b_en) eb[k] = (wr && mo[k] == 1 && b_addr == a_addr) ? a_data : (bin ? mm[k][b_addr] : 8'h00);
                if (wr) mm[k][a_addr] = a_data;
                if (clr_req) begin
                    cleft[k] = dep[k];
                    for (int j = 0; j < 64; j++) mm[k][j] = 0;
                end
            end
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        step();
        @(negedge clk);
        chk_all();
    endtask
    task automatic drv(logic ae, logic we, logic [5:0] aa, logic [7:0] ad, logic be, logic [5:0] ba, logic cr);
        a_en = ae; a_we = we; a_addr = aa; a_data = ad; b_en = be; b_addr = ba; clr_req = cr;
        cyc();
    endtask
    task automatic idle(int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic arst();
        #2 rst = 1;
        mreset();
        #1 chk_all();
        @(negedge clk);
        rst = 0;
    endtask
    initial begin
        mreset();
        #1 rst = 1;
        #3 chk_all();
        @(negedge clk);
        rst = 0;
        idle(64);
        for (int i = 0; i < 64; i++) drv(1, 0, 6'(i), 0, 1, 6'(63 - i), 0);
        drv(1, 1, 1, 8'hA1, 0, 0, 0);
        drv(1, 1, 2, 8'hB2, 0, 0, 0);
        drv(1, 1, 3, 8'hC3, 0, 0, 0);
        drv(1, 0, 2, 0, 1, 1, 0);
        chk("tp_a_out", 32'(ao[0]), 32'h B2);
        chk("tp_b_out", 32'(bo[0]), 32'h A1);
        idle(1);
        chk("tp_a_valid_drop", 32'(av[0]), 0);
        drv(1, 1, 50, 8'hDF, 0, 0, 0);
        drv(1, 1, 50, 8'hEE, 1, 50, 0);
        chk("rdw0_a", 32'(ao[0]), 32'h DF);
        chk("rdw0_b", 32'(bo[0]), 32'h DF);
        chk("rdw1_a", 32'(ao[1]), 32'h EE);
        chk("rdw1_b", 32'(bo[1]), 32'h EE);
        drv(0, 0, 0, 0, 1, 50, 0);
        chk("rdw0_after", 32'(bo[0]), 32'h EE);
        drv(1, 1, 50, 8'hDF, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1);
        drv(1, 1, 5, 8'h55, 0, 0, 0);
        idle(28);
        drv(0, 0, 0, 0, 0, 0, 1);
        idle(34);
        drv(1, 0, 5, 0, 1, 50, 0);
        chk("clr_a5", 32'(ao[0]), 0);
        chk("clr_b50", 32'(bo[0]), 0);
        drv(1, 1, 9, 8'h39, 0, 0, 1);
        idle(20);
        arst();
        idle(64);
        drv(1, 0, 9, 0, 1, 9, 0);
        arst();
        idle(64);
        drv(1, 1, 50, 8'h77, 0, 0, 0);
        drv(1, 0, 50, 0, 0, 0, 0);
        chk("d48_oor_out", 32'(ao[2]), 0);
        chk("d48_oor_valid", 32'(av[2]), 1);
        drv(1, 1, 47, 8'h5A, 0, 0, 0);
        drv(1, 0, 47, 0, 1, 47, 0);
        chk("d48_last_a", 32'(ao[2]), 32'h 5A);
        chk("d48_last_b", 32'(bo[2]), 32'h 5A);
        for (int i = 0; i < 600; i++) begin
            logic [5:0] aa;
            aa = 6'($urandom_range(0, 63));
            drv($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), aa, 8'($urandom),
                $urandom_range(0, 3) != 0, ($urandom_range(0, 2) == 0) ? aa : 6'($urandom_range(0, 63)),
                $urandom_range(0, 149) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
